// File: rtl/uart_rx_buffered_if.sv
// Read-side bus of the buffered UART receiver: show-ahead FIFO head plus occupancy flags.
// The controller (master) pops with rd_en; the receiver (slave) drives data and status.
interface uart_rx_buffered_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
);
  localparam int CW = $clog2(BUFFER_SIZE) + 1;

  logic                    rd_en;
  logic [PAYLOAD_BITS-1:0] rd_data;
  logic                    empty;
  logic                    full;
  logic [CW-1:0]           count;

  modport master (output rd_en, input rd_data, input empty, input full, input count);
  modport slave  (input rd_en, output rd_data, output empty, output full, output count);
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1-style, mid-bit sampling) feeding a show-ahead FIFO.
// Frames with a low stop bit raise frame_error; good frames refused by a full FIFO raise overrun.
module uart_rx_buffered #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  output logic               frame_error,
  output logic               overrun,
  uart_rx_buffered_if.slave  bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = $clog2(PAYLOAD_BITS + 1);
  localparam int AW           = $clog2(BUFFER_SIZE);
  localparam int CW           = AW + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
  localparam logic [CW-1:0]    DEPTH     = CW'(BUFFER_SIZE);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic                    rx_p0;
  logic                    rx_s;
  logic [PAYLOAD_BITS-1:0] shift;
  logic [PAYLOAD_BITS-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    empty;
  logic                    full;

  logic bit_done;
  logic stop_sample;
  logic push_ok;
  logic push;
  logic pop;

  // Stage p0 -> s: two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  assign bit_done    = (cnt == BIT_LAST);
  assign stop_sample = (state == STOP) && bit_done;
  // A full FIFO still accepts when the same edge pops, keeping occupancy unchanged.
  assign push_ok     = !full || bus.rd_en;
  assign push        = stop_sample && rx_s && push_ok;
  assign pop         = bus.rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == DATA_LAST) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt         <= '0;
            state       <= IDLE;
            frame_error <= !rx_s;
            overrun     <= rx_s && !push_ok;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_ff @(posedge clk) begin
    if (state == DATA && bit_done) shift <= {rx_s, shift[PAYLOAD_BITS-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  assign empty       = (count == '0);
  assign full        = (count == DEPTH);
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count;
  // Memory is never cleared, so the head is masked to zero whenever nothing is stored.
  assign bus.rd_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: queue-based reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_uart_rx_buffered;
  localparam int CLK_FREQ = 1600000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = 16;
  localparam int HALF     = 8;
  localparam int DEPTH    = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic rd_en = 1'b0;
  logic frame_error;
  logic overrun;

  uart_rx_buffered_if #(.PAYLOAD_BITS(8), .BUFFER_SIZE(DEPTH)) bus ();
  assign bus.rd_en = rd_en;

  uart_rx_buffered #(
    .CLK_FREQ(CLK_FREQ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(8), .BUFFER_SIZE(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .frame_error(frame_error), .overrun(overrun), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  byte unsigned mq[$];
  logic         fe_exp = 1'b0;
  logic         ov_exp = 1'b0;
  int           stop_edge = -1;
  logic [7:0]   stop_byte = 8'h00;
  logic         stop_bit = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: FIFO as a queue, frame outcome applied at the stop-sample edge.
  always @(posedge clk) begin
    cyc++;
    fe_exp = 1'b0;
    ov_exp = 1'b0;
    if (reset) begin
      mq.delete();
      stop_edge = -1;
    end else begin
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (cyc == stop_edge) begin
        if (!stop_bit)              fe_exp = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(stop_byte);
        else                        ov_exp = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (frame_error) fe_cnt++;
    if (overrun)     ov_cnt++;
    if (reset) begin
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_count", bus.count, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_frame_error", frame_error, 0);
      check("rst_overrun", overrun, 0);
    end else begin
      check("count", bus.count, mq.size());
      check("empty", bus.empty, mq.size() == 0);
      check("full", bus.full, mq.size() == DEPTH);
      if (mq.size() > 0) check("rd_data", bus.rd_data, mq[0]);
      check("frame_error", frame_error, fe_exp);
      check("overrun", overrun, ov_exp);
    end
  end

  // Called on a negedge. Mid-stop sample lands after 2 sync edges + 1 detect edge,
  // half a bit to mid-start, then nine full bit periods.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int idle);
    stop_byte = b;
    stop_bit  = stop;
    stop_edge = cyc + 3 + HALF + 9 * CPB;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (idle) @(negedge clk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int ov0;
    logic [7:0] exp_b;
    reset = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_rst_empty", bus.empty, 1);
    check("lit_rst_full", bus.full, 0);
    check("lit_rst_count", bus.count, 0);
    check("lit_rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Single good frame, then pop
    send_frame(8'hA5, 1'b1, 4);
    check("a5_empty", bus.empty, 0);
    check("a5_rd_data", bus.rd_data, 8'hA5);
    check("a5_count", bus.count, 1);
    pop_one();
    check("a5_pop_empty", bus.empty, 1);
    check("a5_pop_count", bus.count, 0);

    // Low stop bit
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 40);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_empty", bus.empty, 1);

    // Short glitch on the line
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_count", bus.count, 0);

    // Back-to-back frames into a 4-deep FIFO
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 0);
      if (i == 4) check("fill_full", bus.full, 1);
    end
    repeat (10) @(negedge clk);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_count", bus.count, 4);
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      check("ovr_read", bus.rd_data, exp_b);
      pop_one();
    end
    check("ovr_drained", bus.empty, 1);

    // Simultaneous pop and push while full
    send_frame(8'h11, 1'b1, 2);
    send_frame(8'h22, 1'b1, 2);
    send_frame(8'h33, 1'b1, 2);
    send_frame(8'h44, 1'b1, 2);
    check("sim_full_before", bus.full, 1);
    ov0 = ov_cnt;
    fork
      send_frame(8'h77, 1'b1, 5);
      begin
        @(negedge clk);
        for (int n = 0; n < 400 && cyc != stop_edge - 1; n++) @(negedge clk);
        check("sim_align", cyc, stop_edge - 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    check("sim_count", bus.count, 4);
    check("sim_overrun", ov_cnt - ov0, 0);
    check("sim_head", bus.rd_data, 8'h22);
    pop_one();
    check("sim_r33", bus.rd_data, 8'h33);
    pop_one();
    check("sim_r44", bus.rd_data, 8'h44);
    pop_one();
    check("sim_r77", bus.rd_data, 8'h77);
    pop_one();
    check("sim_empty", bus.empty, 1);

    // Reset in the middle of a frame's data bits
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_rd_data", bus.rd_data, 0);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_count", bus.count, 0);
    send_frame(8'h5A, 1'b1, 10);
    check("post_rst_count5a", bus.count, 1);
    check("post_rst_data", bus.rd_data, 8'h5A);
    check("post_rst_fe", fe_cnt - fe0, 0);
    check("post_rst_ov", ov_cnt - ov0, 0);
    pop_one();
    check("post_rst_empty", bus.empty, 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
